axi_mst_wgen: RTL and testbench

AXI_MST_WGEN -- requirements
Module: axi_mst_wgen

---
 rtl/axi_mst_wgen.sv | 160 ++++++++++++++++
 tb/tb_axi_mst_wgen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mst_wgen.sv
// AXI write-data generator: queues observed AW commands and plays out W bursts
// with LFSR data, narrow-transfer strobes and optional random B/R readies.
module axi_mst_wgen #(
    parameter int          AXI_ID_W   = 4,
    parameter int          AXI_DATA_W = 32,
    parameter int          OSTD_DEPTH = 4,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468,
    parameter int          READY_MODE = 1,
    localparam int         STRB_W     = AXI_DATA_W / 8,
    localparam int         AL_W       = $clog2(STRB_W),
    localparam int         CNT_W      = $clog2(OSTD_DEPTH) + 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  in_awvalid,
    input  logic                  in_awready,
    input  logic [AXI_ID_W-1:0]   in_awid,
    input  logic [7:0]            in_awlen,
    input  logic [2:0]            in_awsize,
    input  logic [AL_W-1:0]       in_awaddr_lo,
    output logic                  out_cmd_full,
    output logic [CNT_W-1:0]      out_ostd_cnt,
    output logic                  out_wvalid,
    output logic                  out_wlast,
    output logic [AXI_ID_W-1:0]   out_wid,
    output logic [AXI_DATA_W-1:0] out_wdata,
    output logic [STRB_W-1:0]     out_wstrb,
    input  logic                  in_wready,
    output logic                  out_bready,
    output logic                  out_rready,
    output logic                  out_err_ovf
);
    localparam int          PTR_W     = CNT_W - 1;
    // Right-shift Galois taps for x^32+x^22+x^2+x+1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [AL_W-1:0]     addr_lo;
    } cmd_t;

    cmd_t             mem_q [OSTD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       beat_cnt_q;
    logic [31:0]      lfsr_q, rlfsr_q;
    logic             err_ovf_q, bready_q, rready_q;

    cmd_t             head;
    logic             wvalid, wlast, full, push_req, push_ok, pop, beat_acc;
    logic [2:0]       esize;
    logic [AL_W-1:0]  lane_base, lane;
    logic [7:0]       lane_off;
    logic [AL_W:0]    nbytes;
    logic [STRB_W-1:0]     strb;
    logic [AXI_DATA_W-1:0] wdata;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    assign head     = mem_q[rd_ptr_q];
    assign full     = (cnt_q == CNT_W'(OSTD_DEPTH));
    assign wvalid   = (cnt_q != '0);
    assign wlast    = wvalid && (beat_cnt_q == head.len);
    assign push_req = in_awvalid && in_awready;
    assign beat_acc = wvalid && in_wready;
    assign pop      = beat_acc && wlast;
    // A full queue can still take a push when the head burst retires this cycle
    assign push_ok  = push_req && (!full || pop);
    assign cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);

    // Lane is derived from the beat count so a stalled beat keeps its strobe
    assign esize     = (head.size > 3'(AL_W)) ? 3'(AL_W) : head.size;
    assign nbytes    = (AL_W+1)'(1) << esize;
    assign lane_base = (head.addr_lo >> esize) << esize;
    assign lane_off  = beat_cnt_q << esize;
    assign lane      = lane_base + lane_off[AL_W-1:0];

    always_comb begin
        strb  = '0;
        wdata = '0;
        for (int b = 0; b < STRB_W; b++) begin
            strb[b] = wvalid && (b >= int'(lane)) && (b < int'(lane) + int'(nbytes));
            if (strb[b])
                wdata[8*b +: 8] = lfsr_q[8*(b%4) +: 8];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < OSTD_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_ovf_q <= 1'b0;
        end else if (srst) begin
            for (int i = 0; i < OSTD_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_ovf_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= '{id: in_awid, len: in_awlen,
                                     size: in_awsize, addr_lo: in_awaddr_lo};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_req && !push_ok)
                err_ovf_q <= 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt_q <= '0;
            lfsr_q     <= LFSR_SEED;
        end else if (srst) begin
            beat_cnt_q <= '0;
            lfsr_q     <= LFSR_SEED;
        end else if (beat_acc) begin
            beat_cnt_q <= wlast ? 8'd0 : beat_cnt_q + 8'd1;
            lfsr_q     <= lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rlfsr_q  <= ~LFSR_SEED;
            bready_q <= 1'b0;
            rready_q <= 1'b0;
        end else if (srst) begin
            rlfsr_q  <= ~LFSR_SEED;
            bready_q <= 1'b0;
            rready_q <= 1'b0;
        end else begin
            rlfsr_q  <= lfsr_next(rlfsr_q);
            bready_q <= (READY_MODE != 0) ? rlfsr_q[0]  : 1'b1;
            rready_q <= (READY_MODE != 0) ? rlfsr_q[16] : 1'b1;
        end
    end

    assign out_cmd_full = full;
    assign out_ostd_cnt = cnt_q;
    assign out_wvalid   = wvalid;
    assign out_wlast    = wlast;
    assign out_wid      = wvalid ? head.id : '0;
    assign out_wdata    = wdata;
    assign out_wstrb    = strb;
    assign out_bready   = bready_q;
    assign out_rready   = rready_q;
    assign out_err_ovf  = err_ovf_q;

endmodule

// File: tb/tb_axi_mst_wgen.sv
// Bench for axi_mst_wgen: queue-based reference model checked every cycle,
// plus directed checks on bursts, narrow strobes, overflow, stalls and resets.
module tb_axi_mst_wgen;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic        aclk = 1'b0, aresetn = 1'b0, srst = 1'b0;
  logic        in_awvalid = 0, in_awready = 0, in_wready = 0;
  logic [3:0]  in_awid = 0;
  logic [7:0]  in_awlen = 0;
  logic [2:0]  in_awsize = 0;
  logic [1:0]  in_awaddr_lo = 0;
  logic        out_cmd_full, out_wvalid, out_wlast, out_bready, out_rready, out_err_ovf;
  logic [2:0]  out_ostd_cnt;
  logic [3:0]  out_wid, out_wstrb;
  logic [31:0] out_wdata;

  axi_mst_wgen dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .in_awvalid(in_awvalid), .in_awready(in_awready), .in_awid(in_awid),
    .in_awlen(in_awlen), .in_awsize(in_awsize), .in_awaddr_lo(in_awaddr_lo),
    .out_cmd_full(out_cmd_full), .out_ostd_cnt(out_ostd_cnt),
    .out_wvalid(out_wvalid), .out_wlast(out_wlast), .out_wid(out_wid),
    .out_wdata(out_wdata), .out_wstrb(out_wstrb), .in_wready(in_wready),
    .out_bready(out_bready), .out_rready(out_rready), .out_err_ovf(out_err_ovf));

  always #5 aclk = ~aclk;

  typedef struct { logic [3:0] id; logic [7:0] len; logic [2:0] size; logic [1:0] addr; } cmd_t;
  cmd_t        mq[$];
  int unsigned mbi;
  logic [31:0] ml, mrl;
  logic        m_ovf, m_br, m_rr;
  bit          obs_beat, obs_last;
  int          tests = 0, fails = 0;

  // Polynomial x^32+x^22+x^2+x+1, Galois form shifting right
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? ((32'h1 << 31) | (32'h1 << 21) | 32'h2 | 32'h1) : 32'h0);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete(); mbi = 0; ml = SEED; mrl = ~SEED; m_ovf = 0; m_br = 0; m_rr = 0;
  endtask

  // Called at a falling edge: compare outputs to the model, then advance the
  // model across the coming rising edge and wait for the next falling edge.
  task automatic cycle();
    logic ev, el, push;
    logic [3:0] estrb, eid;
    logic [31:0] ed;
    int es, nb, lane;
    ev = (mq.size() != 0); el = 0; estrb = 0; ed = 0; eid = 0;
    if (ev) begin
      es   = (mq[0].size > 2) ? 2 : int'(mq[0].size);
      nb   = 1 << es;
      lane = (((int'(mq[0].addr) >> es) << es) + int'(mbi) * nb) % 4;
      for (int b = 0; b < 4; b++)
        if (b >= lane && b < lane + nb) begin
          estrb[b] = 1'b1;
          ed[8*b +: 8] = ml[8*b +: 8];
        end
      el  = (mbi == int'(mq[0].len));
      eid = mq[0].id;
    end
    check("wvalid", out_wvalid, ev);
    check("wlast", out_wlast, el);
    check("wstrb", out_wstrb, estrb);
    check("wdata", out_wdata, ed);
    check("wid", out_wid, eid);
    check("ostd_cnt", out_ostd_cnt, mq.size());
    check("cmd_full", out_cmd_full, mq.size() == 4);
    check("err_ovf", out_err_ovf, m_ovf);
    check("bready", out_bready, m_br);
    check("rready", out_rready, m_rr);
    obs_beat = out_wvalid && in_wready;
    obs_last = obs_beat && out_wlast;
    if (srst) model_clear();
    else begin
      push = in_awvalid && in_awready;
      if (ev && in_wready) begin
        ml = lfsr_step(ml);
        mbi = el ? 0 : mbi + 1;
        if (el) mq.delete(0);
      end
      if (push) begin
        if (mq.size() < 4) mq.push_back('{in_awid, in_awlen, in_awsize, in_awaddr_lo});
        else m_ovf = 1;
      end
      m_br = mrl[0]; m_rr = mrl[16]; mrl = lfsr_step(mrl);
    end
    @(negedge aclk);
  endtask

  task automatic push(input logic [3:0] id, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] a);
    in_awvalid = 1; in_awready = 1; in_awid = id; in_awlen = len; in_awsize = sz; in_awaddr_lo = a;
    cycle();
    in_awvalid = 0; in_awready = 0;
  endtask

  task automatic drain();
    in_wready = 1;
    for (int i = 0; i < 200 && mq.size() != 0; i++) cycle();
    check("drain_empty", out_ostd_cnt, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_wvalid"}, out_wvalid, 0);
    check({tag, "_wlast"}, out_wlast, 0);
    check({tag, "_wstrb"}, out_wstrb, 0);
    check({tag, "_wdata"}, out_wdata, 0);
    check({tag, "_wid"}, out_wid, 0);
    check({tag, "_bready"}, out_bready, 0);
    check({tag, "_rready"}, out_rready, 0);
    check({tag, "_full"}, out_cmd_full, 0);
    check({tag, "_ostd"}, out_ostd_cnt, 0);
    check({tag, "_ovf"}, out_err_ovf, 0);
  endtask

  initial begin
    logic [3:0] nstrb [5];
    int cnt8;
    bit done;
    nstrb = '{4'h4, 4'h8, 4'h1, 4'h2, 4'h4};
    model_clear();

    // Reset state
    @(negedge aclk);
    check_zero_outputs("rst");
    @(negedge aclk);
    aresetn = 1;
    for (int i = 0; i < 8; i++) begin
      in_awvalid = (i == 3);  // valid without ready is not a push
      cycle();
    end
    in_awvalid = 0;

    // Single full-width burst
    in_wready = 1;
    push(4'd3, 8'd3, 3'd2, 2'd0);
    for (int i = 0; i < 4; i++) begin
      check("s1_strb", out_wstrb, 4'hF);
      check("s1_wid", out_wid, 4'd3);
      check("s1_last", out_wlast, i == 3);
      check("s1_cnt", out_ostd_cnt, 1);
      cycle();
    end
    check("s1_cnt_end", out_ostd_cnt, 0);

    // Narrow burst: byte lanes rotate through the word
    push(4'd5, 8'd4, 3'd0, 2'd2);
    for (int i = 0; i < 5; i++) begin
      check("nar_strb", out_wstrb, nstrb[i]);
      check("nar_mask", out_wdata & ~{{8{nstrb[i][3]}}, {8{nstrb[i][2]}}, {8{nstrb[i][1]}}, {8{nstrb[i][0]}}}, 0);
      cycle();
    end

    // Random wready during a len=7 burst, second burst queued behind it
    in_wready = 0;
    push(4'd4, 8'd7, 3'd2, 2'd0);
    push(4'd6, 8'd1, 3'd1, 2'd3);
    cnt8 = 0; done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      in_wready = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
      cycle();
      if (obs_beat) cnt8++;
      if (obs_last) done = 1;
    end
    check("b8_done", done, 1);
    check("b8_beats", cnt8, 8);
    check("b2_start_v", out_wvalid, 1);
    check("b2_start_id", out_wid, 4'd6);
    drain();

    // Randomized traffic with clamped sizes and possible overflow
    for (int i = 0; i < 400; i++) begin
      in_awvalid = ($urandom_range(0, 3) == 0);
      in_awready = $urandom_range(0, 1);
      in_awid = 4'($urandom); in_awlen = 8'($urandom_range(0, 3));
      in_awsize = 3'($urandom); in_awaddr_lo = 2'($urandom);
      in_wready = $urandom_range(0, 1);
      cycle();
    end
    in_awvalid = 0; in_awready = 0;
    drain();
    srst = 1; cycle(); srst = 0;

    // Overflow: five handshakes with the W channel stalled
    in_wready = 0;
    for (int i = 0; i < 5; i++) push(4'(i), 8'd2, 3'd2, 2'd0);
    check("ovf_full", out_cmd_full, 1);
    check("ovf_cnt", out_ostd_cnt, 4);
    check("ovf_flag", out_err_ovf, 1);
    in_wready = 1; cycle(); cycle();
    srst = 1; cycle(); srst = 0;
    check("srst_cnt", out_ostd_cnt, 0);
    check("srst_ovf", out_err_ovf, 0);
    check("srst_wvalid", out_wvalid, 0);
    push(4'd7, 8'd0, 3'd2, 2'd0);
    check("srst_seed", out_wdata, SEED);
    cycle();

    // Push coincident with the final wlast pop while full
    in_wready = 0;
    push(4'd8, 8'd1, 3'd2, 2'd0);
    for (int i = 0; i < 3; i++) push(4'(9 + i), 8'd0, 3'd2, 2'd0);
    check("cp_full", out_cmd_full, 1);
    in_wready = 1;
    for (int i = 0; i < 10 && !out_wlast; i++) cycle();
    push(4'd12, 8'd0, 3'd2, 2'd1);
    check("cp_cnt", out_ostd_cnt, 4);
    check("cp_ovf", out_err_ovf, 0);
    drain();

    // Asynchronous reset in the middle of a burst
    push(4'd2, 8'd5, 3'd2, 2'd0);
    cycle();
    #2 aresetn = 0;
    #1 check_zero_outputs("arst");
    model_clear();
    @(negedge aclk);
    check_zero_outputs("arst_hold");
    aresetn = 1;
    push(4'd1, 8'd0, 3'd2, 2'd0);
    check("arst_seed", out_wdata, SEED);
    check("arst_strb", out_wstrb, 4'hF);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
